stream_pattern_gen: RTL and testbench
=====================================

Name: stream_pattern_gen

Overview:
AXI-Stream test-pattern source with ap_ctrl_hs-style control, used as the upstream stimulus for AXI-MM write datapaths in cocotb benches.
- Successor to the fixed incrementing-word generator. Generalises it to:
  - byte-granular transfer length, with tkeep on the final beat;
  - selectable pattern mode (increment, constant, LFSR) and a programmable seed;
  - zero-length transfers.
- Sits between the testbench or control registers and a stream-to-MM writer.

Parameters:
WIDTH, 32, tdata width in bits; multiple of 8, range 8..512.
KEEP_W, WIDTH/8, derived byte-lane count; do not override.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
size  in  32  transfer length in bytes; sampled on start
mode  in  2  pattern select; sampled on start
seed  in  8  pattern seed; sampled on start
ap_start  in  1  start request
ap_ready  out  1  start accepted (combinational pulse)
ap_done  out  1  transfer complete (registered one-cycle pulse)
ap_idle  out  1  high only in IDLE
tdata  out  WIDTH  stream data
tkeep  out  KEEP_W  byte enables
tvalid  out  1  stream valid
tlast  out  1  final beat
tready  in  1  downstream ready

Behaviour:
- One clock domain. Reset is synchronous and active-high; the clock port is clk and the reset port is reset.
- Reset values (at the first edge with reset=1): state=IDLE, tvalid=0, tlast=0, tkeep=0, tdata=0, ap_done=0, ap_idle=1, byte and beat counters=0.
- Reset mid-transfer: abort immediately. tvalid=0 from the next cycle. No ap_done is issued.
- States: IDLE, STREAM, DONE.
- IDLE:
  - ap_ready = ap_start (combinational).
  - On ap_start: latch size, mode and seed. Beats = ceil(size/KEEP_W). Go to STREAM, or to DONE if size==0.
- STREAM:
  - tvalid=1 on every cycle.
  - A beat completes on tvalid && tready.
  - tlast=1 on the final beat.
  - Final beat tkeep: the low (size mod KEEP_W) bits set, or all ones if the remainder is 0. All other beats: all ones.
  - On the final handshake, go to DONE.
- DONE: ap_done=1 for exactly one cycle, then IDLE. With size==0, ap_done occurs 2 cycles after the start cycle, and no beat is sent.
- First tvalid appears in the cycle after ap_ready (1-cycle latency).
- AXI hold rule: tdata, tkeep and tlast stay stable while tvalid && !tready.
- ap_start is ignored outside IDLE.
- Bytes with tkeep=0 are driven to 0.
- Patterns, with byte lane j, global byte index n = beat*KEEP_W + j, and all arithmetic mod 256:
  - mode 0 INCR: byte = seed + n.
  - mode 1 CONST: byte = seed.
  - mode 2 LFSR:
    - 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1.
    - Initial value {seed, 24'h000001}, which is never all-zero.
    - tdata = LFSR state replicated across the bus. For WIDTH<32, use the low WIDTH bits.
    - Advance exactly once per accepted beat.
  - mode 3: reserved; behaves as INCR.
- Counters are 32 bits wide. A size up to 2^32-1 must not overflow the beat computation; use a 33-bit intermediate for size+KEEP_W-1.

Decomposition:
- Package stream_pattern_pkg:
  - state enum {IDLE, STREAM, DONE};
  - mode enum {PAT_INCR=0, PAT_CONST=1, PAT_LFSR=2};
  - LFSR polynomial tap constant;
  - LFSR init constant 24'h000001.
- Sub-module pattern_lfsr32: 32-bit state with load (value) and advance enable. Instantiated once; top-level replicates its output across tdata.
- Top level: FSM, counters, tkeep/tlast generation, pattern muxing.

Test Plan:
1. WIDTH=32, size=8, mode=0, seed=0x80, tready=1. Expect:
   - ap_ready pulse on the start cycle;
   - beats 0x83828180 then 0x87868584, with tlast on beat 2 and tkeep=0xF on both;
   - ap_done one cycle after beat 2, then ap_idle=1.
2. WIDTH=32, size=6, mode=0, seed=0xFE. Expect:
   - beat1 0x0100FFFE, tkeep 0xF;
   - beat2 0x00000302, tkeep 0x3, tlast=1 (byte wrap checked).
3. size=12, mode=1, seed=0x5A, tready toggling 1,0,0,1,... Expect:
   - 3 beats of 0x5A5A5A5A;
   - tdata, tkeep and tlast held constant on every stalled cycle;
   - exactly 3 handshakes.
4. size=0, ap_start pulse. Expect ap_ready, tvalid never asserted, ap_done 2 cycles after start, back to IDLE.
5. mode=2, seed=0x01, size=8. Expect:
   - beat1 = 0x01000001;
   - beat2 = next LFSR state per the polynomial, checked against a Python model;
   - WIDTH=64 run shows the 32-bit pattern replicated across both halves.
6. size=64; assert reset for 1 cycle after beat 3; ap_start pulsed mid-transfer. Expect:
   - the mid-transfer ap_start has no effect;
   - after reset: tvalid=0, ap_idle=1, no ap_done;
   - a new start with seed 0x10 restarts from byte 0x10.

Source files
------------

// File: rtl/stream_pattern_pkg.sv
// Shared types and constants for the AXI-Stream test-pattern generator.
// The LFSR tap mask encodes x^32+x^22+x^2+x+1 as state bits 31, 21, 1 and 0.
package stream_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_INCR  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_LFSR  = 2'd2
  } mode_e;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [23:0] LFSR_INIT_LO = 24'h000001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pattern_lfsr32.sv
// 32-bit Fibonacci LFSR with a synchronous load and a one-step advance enable.
// Load takes priority so a new transfer always starts from its seed.
module pattern_lfsr32
  import stream_pattern_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_value_i,
  input  logic        advance_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= {8'h00, LFSR_INIT_LO};
    end else if (load_i) begin
      state_q <= load_value_i;
    end else if (advance_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/stream_pattern_gen.sv
// AXI-Stream test-pattern source with ap_ctrl_hs handshake: emits size bytes of an
// INCR / CONST / LFSR pattern, tkeep-trimmed on the final beat, then pulses ap_done.
module stream_pattern_gen
  import stream_pattern_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int KEEP_W = WIDTH / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       size,
  input  logic [1:0]        mode,
  input  logic [7:0]        seed,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  output logic [WIDTH-1:0]  tdata,
  output logic [KEEP_W-1:0] tkeep,
  output logic              tvalid,
  output logic              tlast,
  input  logic              tready
);

  localparam int REM_W = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;

  state_e           state_q, state_d;
  logic [31:0]      beat_cnt_q, beat_cnt_d;
  logic [31:0]      last_beat_q, last_beat_d;
  logic [7:0]       byte_idx_q, byte_idx_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       seed_q, seed_d;
  logic             ap_done_q, ap_done_d;

  logic             lfsr_load;
  logic             lfsr_advance;
  logic [31:0]      lfsr_state;
  logic             is_last;
  logic [31:0]      start_last_beat;
  logic [REM_W-1:0] start_rem;

  // 33-bit rounding sum so size = 2^32-1 cannot wrap the beat count.
  assign start_last_beat = 32'((({1'b0, size} + 33'(KEEP_W - 1)) / 33'(KEEP_W)) - 33'd1);
  assign start_rem       = REM_W'(size % 32'(KEEP_W));
  assign is_last         = (beat_cnt_q == last_beat_q);

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_beat_d  = last_beat_q;
    byte_idx_d   = byte_idx_q;
    rem_d        = rem_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    ap_done_d    = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          mode_d      = mode;
          seed_d      = seed;
          rem_d       = start_rem;
          last_beat_d = start_last_beat;
          beat_cnt_d  = '0;
          byte_idx_d  = '0;
          lfsr_load   = 1'b1;
          state_d     = (size == 32'd0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (tready) begin
          lfsr_advance = 1'b1;
          if (is_last) begin
            ap_done_d = 1'b1;
            state_d   = DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            byte_idx_d = byte_idx_q + 8'(KEEP_W);
          end
        end
      end
      DONE: begin
        // A zero-length start arrives here without ap_done armed; it is raised one cycle later.
        ap_done_d = !ap_done_q;
        if (ap_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      last_beat_q <= '0;
      byte_idx_q  <= '0;
      rem_q       <= '0;
      mode_q      <= '0;
      seed_q      <= '0;
      ap_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      last_beat_q <= last_beat_d;
      byte_idx_q  <= byte_idx_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      ap_done_q   <= ap_done_d;
    end
  end

  pattern_lfsr32 u_lfsr (
    .clk          (clk),
    .reset        (reset),
    .load_i       (lfsr_load),
    .load_value_i ({seed, LFSR_INIT_LO}),
    .advance_i    (lfsr_advance),
    .state_o      (lfsr_state)
  );

  assign ap_ready = (state_q == IDLE) && ap_start;
  assign ap_idle  = (state_q == IDLE);
  assign ap_done  = ap_done_q;
  assign tvalid   = (state_q == STREAM);
  assign tlast    = tvalid && is_last;

  // Outputs derive only from registers that move on a handshake, so they hold under stall.
  always_comb begin
    tkeep = '0;
    tdata = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      tkeep[j] = tvalid && (!is_last || rem_q == '0 || REM_W'(j) < rem_q);
      case (mode_q)
        PAT_CONST: tdata[j*8 +: 8] = seed_q;
        PAT_LFSR:  tdata[j*8 +: 8] = lfsr_state[(j % 4) * 8 +: 8];
        default:   tdata[j*8 +: 8] = seed_q + byte_idx_q + 8'(j);
      endcase
      if (!tkeep[j]) tdata[j*8 +: 8] = 8'h00;
    end
  end

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed bench for stream_pattern_gen: a table of transfers with hand-computed beats,
// plus sequences for stall/hold, zero length, 64-bit LFSR replication and mid-transfer reset.
module tb_stream_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] size;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic        ap_start, ap_start64;
  logic        ap_ready, ap_done, ap_idle;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, tready;
  logic        ap_ready64, ap_done64, ap_idle64;
  logic [63:0] tdata64;
  logic [7:0]  tkeep64;
  logic        tvalid64, tlast64;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  stream_pattern_gen #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .size(size), .mode(mode), .seed(seed),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .tdata(tdata), .tkeep(tkeep), .tvalid(tvalid), .tlast(tlast), .tready(tready)
  );

  stream_pattern_gen #(.WIDTH(64)) u_dut64 (
    .clk(clk), .reset(reset), .size(size), .mode(mode), .seed(seed),
    .ap_start(ap_start64), .ap_ready(ap_ready64), .ap_done(ap_done64), .ap_idle(ap_idle64),
    .tdata(tdata64), .tkeep(tkeep64), .tvalid(tvalid64), .tlast(tlast64), .tready(tready)
  );

  typedef struct packed {
    logic [31:0]      size;
    logic [1:0]       mode;
    logic [7:0]       seed;
    logic [2:0]       nbeats;
    logic [3:0][31:0] data;
    logic [3:0][3:0]  keep;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one 32-bit transfer; with stall set, tready follows 1,0,0,1,0,0,...
  task automatic run_vec(input vec_t v, input bit stall, input string tag);
    int          beat = 0;
    int          cyc  = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic [3:0]  prev_k = '0;
    logic        prev_l = 1'b0;
    @(negedge clk);
    size = v.size; mode = v.mode; seed = v.seed; ap_start = 1'b1; tready = 1'b1;
    #1 check({tag, " ap_ready"}, ap_ready, 1);
    @(posedge clk);
    #1 ap_start = 1'b0;
    while (beat < int'(v.nbeats) && cyc < 40) begin
      @(negedge clk);
      tready = stall ? (cyc % 3 == 0) : 1'b1;
      #1;
      check($sformatf("%s tvalid c%0d", tag, cyc), tvalid, 1);
      if (prev_stall) begin
        check($sformatf("%s hold tdata c%0d", tag, cyc), tdata, prev_d);
        check($sformatf("%s hold tkeep c%0d", tag, cyc), tkeep, prev_k);
        check($sformatf("%s hold tlast c%0d", tag, cyc), tlast, prev_l);
      end
      check($sformatf("%s tdata b%0d", tag, beat), tdata, v.data[beat]);
      check($sformatf("%s tkeep b%0d", tag, beat), tkeep, v.keep[beat]);
      check($sformatf("%s tlast b%0d", tag, beat), tlast, (beat == int'(v.nbeats) - 1));
      prev_d = tdata; prev_k = tkeep; prev_l = tlast; prev_stall = !tready;
      if (tready) beat++;
      cyc++;
    end
    check({tag, " handshakes"}, beat, v.nbeats);
    @(negedge clk);
    tready = 1'b1;
    #1;
    check({tag, " ap_done"}, ap_done, 1);
    check({tag, " tvalid after last"}, tvalid, 0);
    @(negedge clk);
    #1;
    check({tag, " ap_idle"}, ap_idle, 1);
    check({tag, " ap_done width"}, ap_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen_done;

    vecs[0] = '{size: 32'd8,  mode: 2'd0, seed: 8'h80, nbeats: 3'd2,
                data: {32'h0, 32'h0, 32'h87868584, 32'h83828180}, keep: {4'h0, 4'h0, 4'hF, 4'hF}};
    vecs[1] = '{size: 32'd6,  mode: 2'd0, seed: 8'hFE, nbeats: 3'd2,
                data: {32'h0, 32'h0, 32'h00000302, 32'h0100FFFE}, keep: {4'h0, 4'h0, 4'h3, 4'hF}};
    vecs[2] = '{size: 32'd12, mode: 2'd1, seed: 8'h5A, nbeats: 3'd3,
                data: {32'h0, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A}, keep: {4'h0, 4'hF, 4'hF, 4'hF}};
    vecs[3] = '{size: 32'd8,  mode: 2'd2, seed: 8'h01, nbeats: 3'd2,
                data: {32'h0, 32'h0, 32'h02000003, 32'h01000001}, keep: {4'h0, 4'h0, 4'hF, 4'hF}};
    vecs[4] = '{size: 32'd5,  mode: 2'd3, seed: 8'h10, nbeats: 3'd2,
                data: {32'h0, 32'h0, 32'h00000014, 32'h13121110}, keep: {4'h0, 4'h0, 4'h1, 4'hF}};
    vecs[5] = '{size: 32'd1,  mode: 2'd1, seed: 8'hAB, nbeats: 3'd1,
                data: {32'h0, 32'h0, 32'h0, 32'h000000AB}, keep: {4'h0, 4'h0, 4'h0, 4'h1}};
    vecs[6] = '{size: 32'd7,  mode: 2'd2, seed: 8'hFF, nbeats: 3'd2,
                data: {32'h0, 32'h0, 32'h00000002, 32'hFF000001}, keep: {4'h0, 4'h0, 4'h7, 4'hF}};
    vecs[7] = '{size: 32'd4,  mode: 2'd0, seed: 8'h10, nbeats: 3'd1,
                data: {32'h0, 32'h0, 32'h0, 32'h13121110}, keep: {4'h0, 4'h0, 4'h0, 4'hF}};

    reset = 1'b1; size = '0; mode = '0; seed = '0;
    ap_start = 1'b0; ap_start64 = 1'b0; tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset tvalid", tvalid, 0);
    check("reset tlast", tlast, 0);
    check("reset tkeep", tkeep, 0);
    check("reset tdata", tdata, 0);
    check("reset ap_done", ap_done, 0);
    check("reset ap_idle", ap_idle, 1);
    check("reset ap_ready", ap_ready, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    run_vec(vecs[2], 1'b1, "stall_const");
    run_vec(vecs[1], 1'b1, "stall_incr");

    // Zero-length transfer: ap_done two cycles after the start cycle, no beat.
    @(negedge clk);
    size = 32'd0; mode = 2'd0; seed = 8'h00; ap_start = 1'b1;
    #1 check("zero ap_ready", ap_ready, 1);
    @(posedge clk);
    #1 ap_start = 1'b0;
    @(negedge clk);
    #1;
    check("zero c1 tvalid", tvalid, 0);
    check("zero c1 ap_done", ap_done, 0);
    check("zero c1 ap_idle", ap_idle, 0);
    @(negedge clk);
    #1;
    check("zero c2 ap_done", ap_done, 1);
    check("zero c2 tvalid", tvalid, 0);
    @(negedge clk);
    #1;
    check("zero c3 ap_idle", ap_idle, 1);
    check("zero c3 ap_done", ap_done, 0);

    // 64-bit instance: the 32-bit LFSR word appears in both halves.
    @(negedge clk);
    size = 32'd8; mode = 2'd2; seed = 8'h01; ap_start64 = 1'b1;
    #1 check("w64 ap_ready", ap_ready64, 1);
    @(posedge clk);
    #1 ap_start64 = 1'b0;
    @(negedge clk);
    #1;
    check("w64 tvalid", tvalid64, 1);
    check("w64 tdata", tdata64, 64'h01000001_01000001);
    check("w64 tkeep", tkeep64, 8'hFF);
    check("w64 tlast", tlast64, 1);
    @(negedge clk);
    #1 check("w64 ap_done", ap_done64, 1);

    // Mid-transfer ap_start is ignored, then a one-cycle reset aborts without ap_done.
    @(negedge clk);
    size = 32'd64; mode = 2'd0; seed = 8'h00; ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      #1 check($sformatf("abort beat%0d", b), tdata,
               {8'(4 * b + 3), 8'(4 * b + 2), 8'(4 * b + 1), 8'(4 * b)});
    end
    @(negedge clk);
    ap_start = 1'b1; seed = 8'h77; size = 32'd4;
    #1;
    check("abort ap_ready mid", ap_ready, 0);
    check("abort beat3", tdata, 32'h0F0E0D0C);
    @(posedge clk);
    #1 ap_start = 1'b0;
    @(negedge clk);
    #1;
    check("abort beat4 unaffected", tdata, 32'h13121110);
    check("abort tlast", tlast, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort tvalid", tvalid, 0);
    check("abort ap_idle", ap_idle, 1);
    check("abort tdata", tdata, 0);
    seen_done = ap_done;
    repeat (3) begin
      @(negedge clk);
      #1 seen_done = seen_done | ap_done;
    end
    check("abort no ap_done", seen_done, 0);
    run_vec(vecs[7], 1'b0, "restart");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
